// File: rtl/sr_cmd_pkg.sv
// Shared types for the SR flip-flop command sequencer: request encoding,
// sequencer states and the hold-off counter width.
package sr_cmd_pkg;

  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Small synchronous FIFO with extra-bit pointers; head entry is visible on
// dout whenever the FIFO is non-empty.
module sr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers differ only in the wrap bit when every slot is occupied.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer in front of SR_ff: buffers set/reset/toggle requests and
// dispatches them as exclusive one-cycle s/r pulses separated by a hold-off gap.
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [1:0]       req_cmd,
  output logic             req_ready,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_dout;
  state_e            state;
  logic [HOLD_W-1:0] hold_cnt;

  // Returns {s, r}; a toggle drives the flip-flop to the opposite of q.
  function automatic logic [1:0] resolve_sr(input logic [1:0] cmd, input logic q);
    logic [1:0] sr;
    case (cmd)
      CMD_SET:    sr = 2'b10;
      CMD_RESET:  sr = 2'b01;
      CMD_TOGGLE: sr = q ? 2'b01 : 2'b10;
      default:    sr = 2'b00;
    endcase
    return sr;
  endfunction

  // NOPs complete the handshake but never occupy a slot.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full && (req_cmd != CMD_NOP);
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  sr_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (req_cmd),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      cmd_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {s, r} <= resolve_sr(fifo_dout, q_fb);
            state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          s         <= 1'b0;
          r         <= 1'b0;
          cmd_count <= cmd_count + 1'b1;
          if (HOLD_CYCLES > 0) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state <= ST_IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          s     <= 1'b0;
          r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer (DEPTH=4, HOLD_CYCLES=2, CNT_W=8).
module tb_sr_cmd_sequencer;
  import sr_cmd_pkg::*;

  localparam int DEPTH       = 4;
  localparam int HOLD_CYCLES = 2;
  localparam int CNT_W       = 8;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             req_valid = 1'b0;
  logic [1:0]       req_cmd   = 2'b00;
  logic             q_fb      = 1'b0;
  logic             req_ready;
  logic             s;
  logic             r;
  logic             busy;
  logic [CNT_W-1:0] cmd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pcyc[$];
  bit ps[$];
  bit s_prev = 1'b0;
  bit r_prev = 1'b0;
  bit seen_255 = 1'b0;

  sr_cmd_sequencer #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor: exclusivity, single-cycle width and a log of every pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (s && r) begin
        n_fail++;
        $display("FAIL sr_exclusive: s=%0b r=%0b at cycle %0d, required not both high", s, r, cyc);
      end
      n_checks++;
      if ((s && s_prev) || (r && r_prev)) begin
        n_fail++;
        $display("FAIL pulse_width: s=%0b r=%0b high two cycles at cycle %0d, required width 1", s, r, cyc);
      end
      if (s || r) begin
        pcyc.push_back(cyc);
        ps.push_back(s);
      end
      if (cmd_count == 8'd255) seen_255 = 1'b1;
      s_prev = s;
      r_prev = r;
    end else begin
      s_prev = 1'b0;
      r_prev = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log;
    pcyc.delete();
    ps.delete();
  endtask

  task automatic test_reset;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL rst_s: got %0b required 0", s); end
    n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL rst_r: got %0b required 0", r); end
    n_checks++; if (cmd_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", cmd_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b required 1", req_ready); end
    rst_n = 1'b1;
    tick();
    req_valid = 1'b1;
    req_cmd   = CMD_SET;
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL rst_pre_drive_s: got %0b required 1", s); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL rst_async_s: got %0b required 0", s); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %0b required 0", busy); end
    n_checks++; if (cmd_count !== 8'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d required 0", cmd_count); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %0b required 1", req_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_set;
    logic [CNT_W-1:0] base;
    int acc;
    clear_log();
    base      = cmd_count;
    req_valid = 1'b1;
    req_cmd   = CMD_SET;
    tick();
    acc       = cyc;
    req_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL set_busy_queued: got %0b required 1", busy); end
    tick();
    n_checks++; if (s !== 1'b1 || r !== 1'b0) begin n_fail++; $display("FAIL set_pulse: got s=%0b r=%0b required s=1 r=0", s, r); end
    n_checks++; if (cmd_count !== base) begin n_fail++; $display("FAIL set_count_drive: got %0d required %0d", cmd_count, base); end
    tick();
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL set_pulse_end: got %0b required 0", s); end
    n_checks++; if (cmd_count !== base + 8'd1) begin n_fail++; $display("FAIL set_count: got %0d required %0d", cmd_count, base + 8'd1); end
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL set_busy_done: got %0b required 0", busy); end
    repeat (3) tick();
    n_checks++;
    if (pcyc.size() != 1) begin
      n_fail++; $display("FAIL set_npulses: got %0d required 1", pcyc.size());
    end else if (ps[0] !== 1'b1 || pcyc[0] != acc + 1) begin
      n_fail++; $display("FAIL set_pulse_log: got s=%0b cycle %0d required s=1 cycle %0d", ps[0], pcyc[0], acc + 1);
    end
  endtask

  task automatic test_toggle;
    logic [CNT_W-1:0] base;
    int acc;
    bit exp_s[3];
    exp_s = '{1'b0, 1'b1, 1'b0};
    clear_log();
    base      = cmd_count;
    q_fb      = 1'b1;
    req_valid = 1'b1;
    req_cmd   = CMD_TOGGLE;
    tick();
    acc = cyc;
    req_cmd = CMD_TOGGLE;
    tick();
    q_fb    = 1'b0;
    req_cmd = CMD_RESET;
    tick();
    req_valid = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (pcyc.size() != 3) begin
      n_fail++; $display("FAIL toggle_npulses: got %0d required 3", pcyc.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (ps[j] !== exp_s[j] || pcyc[j] != acc + 1 + 4 * j) begin
          n_fail++;
          $display("FAIL toggle_pulse%0d: got s=%0b cycle %0d required s=%0b cycle %0d",
                   j, ps[j], pcyc[j], exp_s[j], acc + 1 + 4 * j);
        end
      end
    end
    n_checks++; if (cmd_count !== base + 8'd3) begin n_fail++; $display("FAIL toggle_count: got %0d required %0d", cmd_count, base + 8'd3); end
  endtask

  task automatic test_burst;
    logic [CNT_W-1:0] base;
    int drop_i;
    int waited;
    clear_log();
    base   = cmd_count;
    drop_i = -1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_cmd   = (i % 2 == 0) ? CMD_SET : CMD_RESET;
      waited    = 0;
      while (!req_ready && waited < 20) begin
        if (drop_i < 0) drop_i = i;
        tick();
        waited++;
      end
      if (waited >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL burst_ready_timeout: req %0d not accepted in 20 cycles", i);
      end
      tick();
    end
    req_valid = 1'b0;
    n_checks++; if (drop_i != 5) begin n_fail++; $display("FAIL burst_ready_drop: got first stall at request %0d required 5", drop_i); end
    repeat (30) tick();
    n_checks++;
    if (pcyc.size() != 6) begin
      n_fail++; $display("FAIL burst_npulses: got %0d required 6", pcyc.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        n_checks++;
        if (ps[j] !== (j % 2 == 0)) begin
          n_fail++; $display("FAIL burst_order%0d: got s=%0b required s=%0b", j, ps[j], (j % 2 == 0));
        end
        if (j > 0) begin
          n_checks++;
          if (pcyc[j] - pcyc[j-1] != 4) begin
            n_fail++; $display("FAIL burst_period%0d: got %0d cycles required 4", j, pcyc[j] - pcyc[j-1]);
          end
        end
      end
    end
    n_checks++; if (cmd_count !== base + 8'd6) begin n_fail++; $display("FAIL burst_count: got %0d required %0d", cmd_count, base + 8'd6); end
  endtask

  task automatic test_nop;
    logic [CNT_W-1:0] base;
    clear_log();
    base      = cmd_count;
    req_valid = 1'b1;
    req_cmd   = CMD_NOP;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL nop_ready%0d: got %0b required 1", i, req_ready); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy%0d: got %0b required 0", i, busy); end
    end
    req_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (pcyc.size() != 0) begin n_fail++; $display("FAIL nop_pulses: got %0d required 0", pcyc.size()); end
    n_checks++; if (cmd_count !== base) begin n_fail++; $display("FAIL nop_count: got %0d required %0d", cmd_count, base); end
  endtask

  task automatic test_wrap;
    int waited;
    int n_r;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    seen_255 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      req_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      req_valid = 1'b1;
      req_cmd   = CMD_SET;
      waited    = 0;
      while (!req_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (waited >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL wrap_ready_timeout: req %0d not accepted in 20 cycles", i);
      end
      tick();
    end
    req_valid = 1'b0;
    waited = 0;
    while (busy && waited < 100) begin
      tick();
      waited++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: busy=%0b after 100 cycles required 0", busy); end
    tick();
    n_checks++; if (seen_255 !== 1'b1) begin n_fail++; $display("FAIL wrap_seen_255: got %0b required 1", seen_255); end
    n_checks++; if (cmd_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count: got %0d required 0", cmd_count); end
    n_checks++; if (pcyc.size() != 256) begin n_fail++; $display("FAIL wrap_npulses: got %0d required 256", pcyc.size()); end
    n_r = 0;
    foreach (ps[j]) if (!ps[j]) n_r++;
    n_checks++; if (n_r != 0) begin n_fail++; $display("FAIL wrap_r_pulses: got %0d required 0", n_r); end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_toggle();
    test_burst();
    test_nop();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
Upstream command stage for the SR flip-flop (`SR_ff`). Accepts set/reset/toggle requests over a valid/ready handshake and buffers them in a small FIFO. Dispatches each one as a single-cycle pulse on `s` or `r`, followed by a programmable hold-off gap. Guarantees the flip-flop never sees `s` and `r` high together, and resolves toggle requests from the flip-flop's `q` feedback.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 2, idle cycles (s=r=0) after each pulse; 0 allowed; max 15.
- CNT_W, 8, width of `cmd_count`.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_cmd  input  2  00 NOP, 01 RESET, 10 SET, 11 TOGGLE.
- req_ready  output  1  request can be accepted this cycle.
- q_fb  input  1  `q` from the downstream `SR_ff`.
- s  output  1  set pulse to `SR_ff`; registered.
- r  output  1  reset pulse to `SR_ff`; registered.
- busy  output  1  FSM not IDLE, or FIFO non-empty.
- cmd_count  output  CNT_W  number of pulses dispatched; wraps.

Behaviour:
Reset:
- Asynchronous on rst_n low, including mid-operation.
- s=0, r=0, cmd_count=0, FSM=IDLE, FIFO emptied (pointers=0), busy=0.
- req_ready=1, since it is combinational !full.
- A pulse in flight is cut immediately.

Handshake:
- Accept iff req_valid && req_ready at a rising edge.
- req_ready = !fifo_full; no dependence on req_valid.
- A NOP is accepted but not stored. It produces no pulse and no count change.
- The requester holds req_cmd stable while valid && !ready.

FIFO:
- DEPTH entries, 2-bit command each.
- Pointers are log2(DEPTH)+1 bits; full/empty decided by MSB compare; wrap-around is natural.
- Simultaneous push and pop is legal when not empty; occupancy is unchanged.
- There is no push when full, because ready is low.

FSM states: IDLE, DRIVE, HOLD.
- IDLE:
  - If FIFO non-empty: pop the head, go to DRIVE, and register the pulse.
  - SET gives s=1. RESET gives r=1.
  - TOGGLE gives r=1 if q_fb=1, else s=1. q_fb is sampled at the pop edge.
- DRIVE: lasts exactly one cycle.
  - On exit: s=r=0, cmd_count += 1 (mod 2^CNT_W).
  - Next state is HOLD if HOLD_CYCLES>0, else IDLE.
- HOLD:
  - Counter loads HOLD_CYCLES-1 on entry and decrements each cycle.
  - Go to IDLE when it reaches 0.
  - s=r=0 throughout.

Latency and rate:
- A request accepted at edge k into an empty FIFO, with FSM in IDLE, is popped at edge k+1.
- The s/r pulse is high from edge k+1 to edge k+2. There is no bypass path.
- Back-to-back pulses start every HOLD_CYCLES+2 cycles (DRIVE + HOLD + one IDLE).

Invariants:
- s && r is never 1.
- At most one of s or r is high per dispatched command; each pulse is exactly one cycle wide.
- Commands are dispatched in acceptance order.
- Requests keep being accepted during DRIVE and HOLD while not full.

Decomposition:
- Package `sr_cmd_pkg`:
  - typedef enum for cmd (CMD_NOP, CMD_RESET, CMD_SET, CMD_TOGGLE);
  - typedef enum for FSM state (ST_IDLE, ST_DRIVE, ST_HOLD);
  - localparam HOLD_W=4.
- One sub-module, `sr_cmd_fifo`, parameterised on DEPTH and width 2:
  - ports clk, rst_n, push, din, pop, dout, full, empty;
  - same asynchronous active-low reset.
- The top level holds the FSM, the hold counter, toggle resolution and `cmd_count`.

Test Plan (DEPTH=4, HOLD_CYCLES=2, CNT_W=8; drive inputs on negedge):
1. Reset: hold rst_n=0 for 3 cycles → s=r=0, cmd_count=0, busy=0, req_ready=1. Then start a SET pulse and drop rst_n mid-DRIVE → s falls immediately (no edge needed), FIFO empty, count 0.
2. Single SET accepted at edge k → s=1 exactly during [k+1,k+2), r=0 throughout, cmd_count=1 after edge k+2, busy low by edge k+5.
3. TOGGLE with q_fb=1 → one r pulse. TOGGLE with q_fb=0 → one s pulse. RESET → r pulse. Each pulse is one cycle wide and pulses are 4 cycles apart.
4. Burst of 6 back-to-back SET/RESET alternating with req_valid=1 → req_ready drops when 4 entries are stored. All 6 are dispatched in order at a 4-cycle period. No request is lost or duplicated; cmd_count=6.
5. NOP stream of 5 → all accepted in consecutive cycles, no pulse, cmd_count unchanged, busy stays 0.
6. 256 SETs with a random-gap requester → cmd_count wraps 255→0. A monitor asserts !(s&&r) every cycle and pulse width=1 throughout.
